// File: rtl/hazard_ctrl_if.sv
// ID->EX issue/hazard bus between the decode stage and hazard_ctrl.
// master: decode side (drives ID fields, ex_hold, flush)
// slave : hazard_ctrl (drives operand selects, stall and issue)
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rega_addr;
  logic              id_rega_used;
  logic              id_a_is_pc;
  logic [REG_AW-1:0] id_regb_addr;
  logic              id_regb_used;
  logic              id_b_is_imm;
  logic              id_b_is_pc;
  logic [REG_AW-1:0] id_rd_addr;
  logic              id_rd_we;
  logic              ex_hold;
  logic              flush;
  logic [1:0]        opmux_a;
  logic [1:0]        opmux_b;
  logic              id_stall;
  logic              issue;

  modport master (
    output id_valid, id_rega_addr, id_rega_used, id_a_is_pc,
    output id_regb_addr, id_regb_used, id_b_is_imm, id_b_is_pc,
    output id_rd_addr, id_rd_we, ex_hold, flush,
    input  opmux_a, opmux_b, id_stall, issue
  );

  modport slave (
    input  id_valid, id_rega_addr, id_rega_used, id_a_is_pc,
    input  id_regb_addr, id_regb_used, id_b_is_imm, id_b_is_pc,
    input  id_rd_addr, id_rd_we, ex_hold, flush,
    output opmux_a, opmux_b, id_stall, issue
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Issue/hazard controller at the ID->EX boundary. Keeps a 3-slot scoreboard
// (EX, MEM, WB) of in-flight destination registers, stalls ID on EX/MEM
// producers and selects WB forwarding for WB producers.
// Optional macro HAZARD_STATS_EN adds saturating stall/forward counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned NUM_SRC_CHECK = 2
) (
  input  logic          clk,
  input  logic          rst,
`ifdef HAZARD_STATS_EN
  output logic [31:0]   o_stat_stall_cycles,
  output logic [31:0]   o_stat_fwd_count,
`endif
  hazard_ctrl_if.slave  bus
);

  localparam logic [1:0] OPMUX_A_RA  = 2'd0;
  localparam logic [1:0] OPMUX_A_PC  = 2'd1;
  localparam logic [1:0] OPMUX_A_WB  = 2'd2;
  localparam logic [1:0] OPMUX_B_RB  = 2'd0;
  localparam logic [1:0] OPMUX_B_PC  = 2'd1;
  localparam logic [1:0] OPMUX_B_IMM = 2'd2;
  localparam logic [1:0] OPMUX_B_WB  = 2'd3;

  // Scoreboard slots
  logic              r_ex_valid, r_mem_valid, r_wb_valid;
  logic              r_ex_we, r_mem_we, r_wb_we;
  logic [REG_AW-1:0] r_ex_rd, r_mem_rd, r_wb_rd;

  logic                     w_a_chk, w_b_chk;
  logic                     w_a_wb, w_b_wb;
  logic [NUM_SRC_CHECK-1:0] w_young;  // [0]=A, [1]=B
  logic                     w_hazard;
  logic                     w_stall;
  logic                     w_issue;
  logic [1:0]               w_opmux_a, w_opmux_b;

  function automatic logic slot_hit(input logic v, input logic we,
                                    input logic [REG_AW-1:0] rd,
                                    input logic [REG_AW-1:0] addr);
    return v && we && (rd == addr);
  endfunction

  // Dependency detection; r0 and non-register operands never depend
  always_comb begin
    w_young  = '0;
    w_a_chk  = bus.id_rega_used && !bus.id_a_is_pc && (bus.id_rega_addr != '0);
    w_b_chk  = bus.id_regb_used && !bus.id_b_is_imm && !bus.id_b_is_pc &&
               (bus.id_regb_addr != '0);
    w_young[0] = w_a_chk && (slot_hit(r_ex_valid, r_ex_we, r_ex_rd, bus.id_rega_addr) ||
                             slot_hit(r_mem_valid, r_mem_we, r_mem_rd, bus.id_rega_addr));
    w_young[1] = w_b_chk && (slot_hit(r_ex_valid, r_ex_we, r_ex_rd, bus.id_regb_addr) ||
                             slot_hit(r_mem_valid, r_mem_we, r_mem_rd, bus.id_regb_addr));
    w_a_wb   = w_a_chk && slot_hit(r_wb_valid, r_wb_we, r_wb_rd, bus.id_rega_addr);
    w_b_wb   = w_b_chk && slot_hit(r_wb_valid, r_wb_we, r_wb_rd, bus.id_regb_addr);
    w_hazard = |w_young;
    w_stall  = bus.id_valid && (w_hazard || bus.ex_hold);
    w_issue  = bus.id_valid && !w_stall && !bus.flush;
  end

  // Operand selects; a younger producer beats a WB match
  always_comb begin
    w_opmux_a = OPMUX_A_RA;
    w_opmux_b = OPMUX_B_RB;
    if (bus.id_valid) begin
      if (bus.id_a_is_pc)          w_opmux_a = OPMUX_A_PC;
      else if (w_a_wb && !w_young[0]) w_opmux_a = OPMUX_A_WB;

      if (bus.id_b_is_pc)          w_opmux_b = OPMUX_B_PC;
      else if (bus.id_b_is_imm)    w_opmux_b = OPMUX_B_IMM;
      else if (w_b_wb && !w_young[1]) w_opmux_b = OPMUX_B_WB;
    end
  end

  assign bus.opmux_a  = w_opmux_a;
  assign bus.opmux_b  = w_opmux_b;
  assign bus.id_stall = w_stall;
  assign bus.issue    = w_issue;

  // Slot advance; ex_hold freezes the whole pipe, a non-issue inserts a bubble
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_valid  <= 1'b0;
      r_mem_valid <= 1'b0;
      r_wb_valid  <= 1'b0;
      r_ex_we     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_wb_we     <= 1'b0;
      r_ex_rd     <= '0;
      r_mem_rd    <= '0;
      r_wb_rd     <= '0;
    end else if (!bus.ex_hold) begin
      r_wb_valid  <= r_mem_valid;
      r_wb_we     <= r_mem_we;
      r_wb_rd     <= r_mem_rd;
      r_mem_valid <= r_ex_valid;
      r_mem_we    <= r_ex_we;
      r_mem_rd    <= r_ex_rd;
      r_ex_valid  <= w_issue;
      r_ex_we     <= bus.id_rd_we;
      r_ex_rd     <= bus.id_rd_addr;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stat_stall, r_stat_fwd;
  logic        w_fwd_sel;

  assign w_fwd_sel = (w_opmux_a == OPMUX_A_WB) || (w_opmux_b == OPMUX_B_WB);

  // Saturating hazard-stall and forwarded-issue counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stat_stall <= '0;
      r_stat_fwd   <= '0;
    end else begin
      if (bus.id_valid && w_hazard && !bus.ex_hold && (r_stat_stall != '1)) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
      if (w_issue && w_fwd_sel && (r_stat_fwd != '1)) begin
        r_stat_fwd <= r_stat_fwd + 32'd1;
      end
    end
  end

  assign o_stat_stall_cycles = r_stat_stall;
  assign o_stat_fwd_count    = r_stat_fwd;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

  localparam logic [31:0] A_RA = 0, A_PC = 1, A_WB = 2;
  localparam logic [31:0] B_RB = 0, B_PC = 1, B_IMM = 2, B_WB = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_pass   = 0;

  hazard_ctrl_if #(.REG_AW(5)) bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stat_stall, stat_fwd;
`endif

  hazard_ctrl #(.REG_AW(5), .NUM_SRC_CHECK(2)) dut (
    .clk                 (clk),
    .rst                 (rst),
`ifdef HAZARD_STATS_EN
    .o_stat_stall_cycles (stat_stall),
    .o_stat_fwd_count    (stat_fwd),
`endif
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic rau,
                       input logic [4:0] rb, input logic rbu,
                       input logic [4:0] rd, input logic we);
    bus.id_valid     = v;
    bus.id_rega_addr = ra;
    bus.id_rega_used = rau;
    bus.id_regb_addr = rb;
    bus.id_regb_used = rbu;
    bus.id_rd_addr   = rd;
    bus.id_rd_we     = we;
    bus.id_a_is_pc   = 1'b0;
    bus.id_b_is_imm  = 1'b0;
    bus.id_b_is_pc   = 1'b0;
    bus.ex_hold      = 1'b0;
    bus.flush        = 1'b0;
  endtask

  task automatic idle(input int n);
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (n) tick();
  endtask

  // Back-to-back producer r5 / consumer of r5 on A
  task automatic scen_fwd();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1);
    #1 check("b2b_prod_issue", bus.issue, 1);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0);
    #1 check("b2b_stall1", bus.id_stall, 1);
    check("b2b_noissue1", bus.issue, 0);
    tick();
    #1 check("b2b_stall2", bus.id_stall, 1);
    tick();
    #1 check("b2b_stall_drop", bus.id_stall, 0);
    check("b2b_issue", bus.issue, 1);
    check("b2b_opa_wb", bus.opmux_a, A_WB);
    tick();
    idle(3);
  endtask

  initial begin
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    repeat (2) tick();
    rst = 1'b1;
    #1 check("rst_opa", bus.opmux_a, A_RA);
    check("rst_opb", bus.opmux_b, B_RB);
    check("rst_stall", bus.id_stall, 0);
    check("rst_issue", bus.issue, 0);

    // Independent instruction
    drive(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd0, 1'b0);
    #1 check("ind_opa", bus.opmux_a, A_RA);
    check("ind_opb", bus.opmux_b, B_RB);
    check("ind_issue", bus.issue, 1);
    check("ind_stall", bus.id_stall, 0);
    tick();
    idle(3);

    scen_fwd();

    // r0 producer never creates a dependency
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd3, 1'b0);
    #1 check("r0_stall", bus.id_stall, 0);
    check("r0_opa", bus.opmux_a, A_RA);
    check("r0_issue", bus.issue, 1);
    tick();
    idle(3);

    // MEM producer r7 held by ex_hold for 3 cycles
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1);
    tick();
    idle(1);
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b0);
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check("hold_stall", bus.id_stall, 1);
      check("hold_noissue", bus.issue, 0);
      check("hold_opa", bus.opmux_a, A_RA);
      tick();
    end
    bus.ex_hold = 1'b0;
    #1 check("hold_mem_stall", bus.id_stall, 1);
    tick();
    #1 check("hold_fwd_stall", bus.id_stall, 0);
    check("hold_fwd_issue", bus.issue, 1);
    check("hold_fwd_opa", bus.opmux_a, A_WB);
    tick();
    idle(3);

    // Immediate B ignores EX producer; PC priority
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0);
    bus.id_b_is_imm = 1'b1;
    #1 check("imm_stall", bus.id_stall, 0);
    check("imm_opb", bus.opmux_b, B_IMM);
    check("imm_issue", bus.issue, 1);
    bus.id_b_is_pc = 1'b1;
    bus.id_rega_addr = 5'd9;
    bus.id_rega_used = 1'b1;
    bus.id_a_is_pc = 1'b1;
    #1 check("pc_opb", bus.opmux_b, B_PC);
    check("pc_opa", bus.opmux_a, A_PC);
    check("pc_stall", bus.id_stall, 0);
    tick();
    idle(3);

    // Flush kills the producer: EX holds a bubble next cycle
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd10, 1'b1);
    bus.flush = 1'b1;
    #1 check("flush_issue", bus.issue, 0);
    check("flush_stall", bus.id_stall, 0);
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("flush_bubble_stall", bus.id_stall, 0);
    check("flush_bubble_opa", bus.opmux_a, A_RA);
    tick();
    idle(3);

    // Distance 2: one stall then WB forward
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd14, 1'b1);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    tick();
    drive(1'b1, 5'd14, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("d2_stall", bus.id_stall, 1);
    tick();
    #1 check("d2_issue", bus.issue, 1);
    check("d2_opa", bus.opmux_a, A_WB);
    tick();
    idle(3);

    // Distance 3 on B: forward without stall
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd11, 1'b1);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0);
    tick();
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0);
    #1 check("d3_stall", bus.id_stall, 0);
    check("d3_opb", bus.opmux_b, B_WB);
    tick();
    idle(3);

    // Two producers of r12: younger match wins over WB
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd12, 1'b1);
    tick();
    tick();
    drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("yp_stall1", bus.id_stall, 1);
    tick();
    #1 check("yp_stall2", bus.id_stall, 1);
    check("yp_opa_ra", bus.opmux_a, A_RA);
    tick();
    #1 check("yp_issue", bus.issue, 1);
    check("yp_opa_wb", bus.opmux_a, A_WB);
    tick();
    idle(3);

    // Reset mid-operation drops the in-flight producer
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd13, 1'b1);
    tick();
    rst = 1'b0;
    idle(1);
    rst = 1'b1;
    drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
    #1 check("mrst_stall", bus.id_stall, 0);
    check("mrst_opa", bus.opmux_a, A_RA);
    tick();
    idle(3);

`ifdef HAZARD_STATS_EN
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    #1 check("stat_rst_stall", stat_stall, 0);
    scen_fwd();
    scen_fwd();
    check("stat_stall_cycles", stat_stall, 4);
    check("stat_fwd_count", stat_fwd, 2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
